x_pcm_to_level: RTL and testbench
=================================

# x_pcm_to_level

Converts a stream of signed PCM samples into a per-clock level code (0..N) for the thermometer-coded DAC path, using a first-order error-feedback (delta-sigma) requantiser that runs at the full clock rate. Accepts samples over a valid/ready handshake at one sample per OSR clocks, holds each sample for OSR clocks, and drives the level into the binary-to-thermometer stage directly downstream (`i_bin` of that stage).

## Interface
- `N`, default 64: number of DAC unit elements; must be a power of two ≥ 2.
- `W`, default 16: PCM sample width, two's complement.
- `OSR`, default 256: clocks per sample; ≥ 2.
- `i_clk`  in  1  clock.
- `i_nrst`  in  1  asynchronous, active-low reset.
- `i_sample`  in  W  signed PCM sample.
- `i_valid`  in  1  `i_sample` valid.
- `o_ready`  out  1  block can accept a sample this cycle.
- `o_bin`  out  $clog2(N)+1  level code, 0..N inclusive, registered.
- `o_underrun`  out  1  one-cycle pulse: a sample tick found no new sample.

## Operation
- Tick counter `cnt` counts 0..OSR-1 and wraps. A tick is the cycle with `cnt == OSR-1`.
- One-entry pending buffer (`pend_q`, `pend_data_q`). `o_ready = !pend_q`. Handshake happens when `i_valid && o_ready`. The sample is captured into pending, except in the bypass case below.
- On a tick:
  - If `pend_q`: active sample ← pending, and `pend_q` clears.
  - Else, if a handshake occurs in the same cycle: active ← `i_sample` directly (bypass), and `pend_q` stays 0.
  - Else: active holds its previous value and `o_underrun` pulses high for 1 cycle.
- Simultaneous tick with `pend_q = 1`: `o_ready` is 0, so no handshake occurs. Pending clears at that edge, and `o_ready` returns to 1 on the next cycle.
- Requantiser, every clock:
  - `u = active + 2^(W-1)` (offset binary, W bits unsigned).
  - `sum = u*N + e_q`, width W+$clog2(N)+1.
  - `o_bin_d = sum >> W`.
  - `e_d = sum[W-1:0]`.
- Range:
  - `u*N ≤ (2^W-1)*N` and `e_q < 2^W`, therefore `o_bin_d ≤ N`. No saturation logic is needed.
  - u = 0 with any `e_q` gives 0.
- Mean of `o_bin` over 2^W/gcd clocks equals `u*N/2^W` exactly.
- The error register is never cleared except by reset. Sample changes carry the residue forward.

## Timing
- Reset values:
  - `o_bin` = 0, `o_underrun` = 0, `o_ready` = 1.
  - `cnt` = 0, `pend_q` = 0.
  - Active sample = 0 (midscale), `e_q` = 0.
- First clock after reset release: `o_bin` = N/2.
- Latency:
  - The sample loaded into active at tick edge T affects `o_bin` from edge T+1.
  - Handshake to first effect ≤ OSR+1 clocks.
- `o_underrun` is registered. It is asserted the cycle after the tick edge, for exactly 1 cycle.
- Reset mid-operation drops the pending sample and returns all state to reset values asynchronously.

## Structure
- Shared package `x_dac_pkg`: level width function/constant `$clog2(N)+1` and the offset constant `2^(W-1)`, both shared with the binary-to-thermometer stage.
- Sub-module `x_osr_tick`: parameterised OSR counter with a `o_tick` output. It is reused by other rate-domain blocks.
- The requantiser and handshake stay in this module.

## Test plan
Bench uses N=64, W=16, OSR=4 unless stated.
- Reset, no stimulus -> `o_bin` = 0 during reset, then 32 constant; `o_ready` = 1; `o_underrun` pulses on every tick.
- Sample 0x0100 held -> after load, `o_bin` repeats 32,32,32,33 (mean 32.25).
- Sample 0x7FFF held (OSR=1024) -> one 63 then 1023 × 64 per 1024 clocks; never exceeds 64.
- Sample 0x8000 -> `o_bin` = 0 constant; `e_q` unchanged.
- Back-to-back valids A, B, C with `i_valid` held high -> B stalls with `o_ready` = 0 until a tick; each sample is active for exactly OSR clocks; no `o_underrun`.
- Reset asserted mid-sample with `pend_q` = 1 -> all outputs return to reset values immediately; the pending sample is never applied.

Source files
------------

// File: rtl/x_dac_pkg.sv
// x_dac_pkg: level-code width and PCM offset shared by the level and thermometer stages
package x_dac_pkg;
  function automatic int lvl_w(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic longint pcm_ofs(input int w);
    return 64'sd1 <<< (w - 1);
  endfunction
endpackage

// File: rtl/x_osr_tick.sv
// x_osr_tick: free-running 0..OSR-1 counter flagging the last cycle of each sample period
module x_osr_tick #(
  parameter int OSR = 256
) (
  input  logic i_clk,
  input  logic i_nrst,
  output logic o_tick
);
  localparam int CW = $clog2(OSR);
  logic [CW-1:0] cnt;
  assign o_tick = cnt == CW'(OSR - 1);
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) cnt <= '0;
    else cnt <= o_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/x_pcm_to_level.sv
// x_pcm_to_level: PCM sample handshake plus first-order error-feedback requantiser to a 0..N level code
module x_pcm_to_level
  import x_dac_pkg::*;
#(
  parameter int N   = 64,
  parameter int W   = 16,
  parameter int OSR = 256
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic [W-1:0]        i_sample,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [lvl_w(N)-1:0] o_bin,
  output logic                o_underrun
);
  localparam int LW = lvl_w(N);
  localparam int K  = $clog2(N);
  localparam int SW = W + LW;
  localparam logic [W-1:0] OFS = W'(pcm_ofs(W));
  logic          tick, hs, underrun_d, pend_q;
  logic [W-1:0]  pend_data_q, act_q, act_d, e_q, u;
  logic [SW-1:0] sum;
  x_osr_tick #(.OSR(OSR)) u_tick (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .o_tick (tick)
  );
  assign o_ready = !pend_q;
  assign hs      = i_valid && o_ready;
  // u*N + e never exceeds (N+1)*2^W - 1, so the top LW bits are always 0..N
  always_comb begin
    u          = act_q + OFS;
    sum        = (SW'(u) << K) + SW'(e_q);
    underrun_d = tick && !pend_q && !hs;
    act_d      = !tick ? act_q : pend_q ? pend_data_q : hs ? i_sample : act_q;
  end
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      act_q       <= '0;
      e_q         <= '0;
      o_bin       <= '0;
      o_underrun  <= 1'b0;
    end else begin
      pend_q      <= !tick && (pend_q || hs);
      pend_data_q <= (hs && !tick) ? i_sample : pend_data_q;
      act_q       <= act_d;
      e_q         <= sum[W-1:0];
      o_bin       <= sum[SW-1:W];
      o_underrun  <= underrun_d;
    end
endmodule

// File: tb/tb_x_pcm_to_level.sv
// tb_x_pcm_to_level: directed checks of handshake timing, requantiser sequences and reset
module tb_x_pcm_to_level;
  localparam int N = 64, W = 16, OSR = 4, LW = 7;
  logic          i_clk = 1'b0, i_nrst = 1'b0, i_valid = 1'b0;
  logic [W-1:0]  i_sample = '0;
  logic          o_ready, o_underrun;
  logic [LW-1:0] o_bin;
  int checks = 0, failures = 0;
  int sum_w, n63, maxb, nunr;
  int seq_a [6] = '{32, 33, 32, 32, 32, 33};

  always #5 i_clk = ~i_clk;

  x_pcm_to_level #(.N(N), .W(W), .OSR(OSR)) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_sample   (i_sample),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bin      (o_bin),
    .o_underrun (o_underrun)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s);
    i_valid  = v;
    i_sample = s;
  endtask

  initial begin
    step(2);
    chk("rst_bin", 32'(o_bin), 0);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_unr", 32'(o_underrun), 0);
    #3 i_nrst = 1'b1;
    step(1);
    chk("first_bin", 32'(o_bin), 32);
    step(2);
    chk("unr_before_tick", 32'(o_underrun), 0);
    step(1);
    chk("unr_tick", 32'(o_underrun), 1);
    chk("idle_bin", 32'(o_bin), 32);
    step(1);
    chk("unr_one_cycle", 32'(o_underrun), 0);
    chk("idle_ready", 32'(o_ready), 1);
    step(3);
    chk("unr_tick2", 32'(o_underrun), 1);
    drive(1'b1, 16'h0080);
    step(1);
    drive(1'b0, '0);
    chk("pend_ready", 32'(o_ready), 0);
    step(3);
    chk("load_unr", 32'(o_underrun), 0);
    chk("load_ready", 32'(o_ready), 1);
    chk("load_bin_old", 32'(o_bin), 32);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s0080_bin", 32'(o_bin), 32);
    end
    drive(1'b1, 16'h8000);
    step(1);
    drive(1'b0, '0);
    chk("byp_ready", 32'(o_ready), 1);
    chk("byp_unr", 32'(o_underrun), 0);
    chk("s0080_bin4", 32'(o_bin), 32);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("neg_full_bin", 32'(o_bin), 0);
    end
    drive(1'b1, 16'h0100);
    step(1);
    drive(1'b0, '0);
    chk("neg_full_bin4", 32'(o_bin), 0);
    chk("byp2_unr", 32'(o_underrun), 0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("s0100_residue_seq", 32'(o_bin), 32'(seq_a[i]));
      if (i == 3) chk("s0100_unr", 32'(o_underrun), 1);
    end
    drive(1'b1, 16'h4000);
    step(1);
    chk("b2b_a_ready", 32'(o_ready), 0);
    drive(1'b1, 16'hC000);
    step(1);
    chk("b2b_tick_ready", 32'(o_ready), 1);
    chk("b2b_tick_unr", 32'(o_underrun), 0);
    chk("b2b_tick_bin", 32'(o_bin), 32);
    step(1);
    chk("b2b_b_ready", 32'(o_ready), 0);
    chk("b2b_a_bin", 32'(o_bin), 48);
    drive(1'b1, 16'h2000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("b2b_a_bin", 32'(o_bin), 48);
    end
    chk("b2b_a_unr", 32'(o_underrun), 0);
    step(1);
    chk("b2b_c_ready", 32'(o_ready), 0);
    chk("b2b_b_bin", 32'(o_bin), 16);
    drive(1'b1, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("b2b_b_bin", 32'(o_bin), 16);
    end
    chk("b2b_b_unr", 32'(o_underrun), 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("b2b_c_bin", 32'(o_bin), 40);
    end
    sum_w = 0; n63 = 0; maxb = 0; nunr = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1);
      sum_w += int'(o_bin);
      if (o_bin == 7'd63) n63++;
      if (int'(o_bin) > maxb) maxb = int'(o_bin);
      if (o_underrun) nunr++;
    end
    chk("pos_full_sum", 32'(sum_w), 65535);
    chk("pos_full_n63", 32'(n63), 1);
    chk("pos_full_max", 32'(maxb), 64);
    chk("pos_full_unr", 32'(nunr), 0);
    drive(1'b0, '0);
    for (int i = 0; i < 8 && o_ready !== 1'b1; i++) step(1);
    chk("drain_ready", 32'(o_ready), 1);
    drive(1'b1, 16'h4000);
    step(1);
    drive(1'b0, '0);
    chk("pend_before_rst", 32'(o_ready), 0);
    #2 i_nrst = 1'b0;
    #1;
    chk("async_rst_bin", 32'(o_bin), 0);
    chk("async_rst_ready", 32'(o_ready), 1);
    chk("async_rst_unr", 32'(o_underrun), 0);
    step(2);
    #3 i_nrst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("post_rst_bin", 32'(o_bin), 32);
      if (i == 4) chk("post_rst_unr", 32'(o_underrun), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
